// File: rtl/vga_pkg.sv
// Shared types and constants for the graphics pipeline screen logic.
package vga_pkg;

    // Screen currently presented by the sequencer.
    typedef enum logic [1:0] {
        SCR_TITLE     = 2'd0,
        SCR_COUNTDOWN = 2'd1,
        SCR_PLAY      = 2'd2,
        SCR_RESULT    = 2'd3
    } screen_t;

    // Text-ROM line offsets used by the character layers.
    localparam logic [7:0] LB_TITLE       = 8'd0;
    localparam logic [7:0] LB_PRESS_START = 8'd1;
    localparam logic [7:0] LB_GET_READY   = 8'd2;
    localparam logic [7:0] LB_WIN         = 8'd3;
    localparam logic [7:0] LB_LOSE        = 8'd4;

    // Countdown digit from the elapsed-third index: 0 -> 3, 1 -> 2, >=2 -> 1.
    function automatic logic [1:0] sat_digit(input logic [31:0] q);
        logic [1:0] d;
        case (q)
            32'd0:   d = 2'd3;
            32'd1:   d = 2'd2;
            default: d = 2'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Vertical-blank rising-edge detector producing a registered one-cycle
// frame_tick. A vblnk already high when reset is released gives no tick
// until vblnk has been seen low once.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic frame_tick
);

    logic vblnk_d;
    logic armed;

    // Delay vblnk, arm after a low sample, and register the edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d    <= 1'b0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblnk_d    <= vblnk;
            armed      <= armed | ~vblnk;
            frame_tick <= vblnk & ~vblnk_d & armed;
        end
    end

endmodule

// File: rtl/gra_screen_ctrl.sv
// Frame-synchronous screen sequencer: title, countdown, play and result
// screens, character-layer enables and text-ROM line bases. All state
// changes happen on frame_tick so a frame never shows a mixed screen.
module gra_screen_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned RESULT_FRAMES    = 300,
    parameter int unsigned BLINK_FRAMES     = 30,
    parameter int unsigned CNT_W            = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic       player_win,
    output logic [1:0] screen,
    output logic       char1_en,
    output logic       char2_en,
    output logic [7:0] char1_line_base,
    output logic [7:0] char2_line_base,
    output logic [1:0] countdown_digit,
    output logic       blink,
    output logic       frame_tick,
    output logic       game_active
);

    localparam int unsigned DIGIT_STEP = (COUNTDOWN_FRAMES >= 3) ? COUNTDOWN_FRAMES / 3 : 1;
    localparam int unsigned BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   CD_LAST    = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0]   RES_LAST   = CNT_W'(RESULT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   DIGIT_DIV  = CNT_W'(DIGIT_STEP);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    screen_t            state;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   cd_quot;
    logic [1:0]         cd_digit;
    logic [BLINK_W-1:0] blink_cnt;
    logic               result_win;
    logic               start_btn_d;
    logic               start_req;
    logic               win_flag;
    logic               lose_flag;
    logic               start_set;
    logic               win_set;
    logic               lose_set;
    logic               tick;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .frame_tick (tick)
    );

    assign frame_tick = tick;

    // Event capture gating and countdown digit decode.
    always_comb begin
        start_set = start_btn & ~start_btn_d & (state != SCR_RESULT);
        win_set   = player_win & (state != SCR_COUNTDOWN);
        lose_set  = game_over  & (state != SCR_COUNTDOWN);
        cd_quot   = frame_cnt / DIGIT_DIV;
        cd_digit  = sat_digit(32'(cd_quot));
    end

    // Sticky requests, screen FSM on frame_tick, and registered output decode.
    // A flag cleared by a transition is re-set by an event in the same cycle,
    // so that event is held for the following tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= SCR_TITLE;
            frame_cnt       <= '0;
            result_win      <= 1'b0;
            start_btn_d     <= 1'b1;
            start_req       <= 1'b0;
            win_flag        <= 1'b0;
            lose_flag       <= 1'b0;
            screen          <= SCR_TITLE;
            char1_en        <= 1'b1;
            char2_en        <= 1'b1;
            char1_line_base <= LB_TITLE;
            char2_line_base <= LB_PRESS_START;
            countdown_digit <= 2'd0;
            game_active     <= 1'b0;
        end else begin
            start_btn_d <= start_btn;
            start_req   <= (state == SCR_RESULT) ? 1'b0 : (start_req | start_set);
            win_flag    <= win_flag | win_set;
            lose_flag   <= lose_flag | lose_set;

            if (tick) begin
                case (state)
                    SCR_TITLE: begin
                        if (start_req) begin
                            state     <= SCR_COUNTDOWN;
                            frame_cnt <= '0;
                            start_req <= start_set;
                        end
                    end
                    SCR_COUNTDOWN: begin
                        win_flag  <= 1'b0;
                        lose_flag <= 1'b0;
                        if (frame_cnt == CD_LAST) begin
                            state     <= SCR_PLAY;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    SCR_PLAY: begin
                        if (win_flag | lose_flag) begin
                            state      <= SCR_RESULT;
                            frame_cnt  <= '0;
                            result_win <= win_flag;
                            win_flag   <= win_set;
                            lose_flag  <= lose_set;
                        end
                    end
                    SCR_RESULT: begin
                        if (frame_cnt == RES_LAST) begin
                            state     <= SCR_TITLE;
                            frame_cnt <= '0;
                            start_req <= 1'b0;
                            win_flag  <= win_set;
                            lose_flag <= lose_set;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                endcase
            end

            screen          <= state;
            game_active     <= (state == SCR_PLAY);
            countdown_digit <= (state == SCR_COUNTDOWN) ? cd_digit : 2'd0;
            case (state)
                SCR_TITLE: begin
                    char1_en        <= 1'b1;
                    char2_en        <= blink;
                    char1_line_base <= LB_TITLE;
                    char2_line_base <= LB_PRESS_START;
                end
                SCR_COUNTDOWN: begin
                    char1_en        <= 1'b1;
                    char2_en        <= 1'b0;
                    char1_line_base <= LB_GET_READY;
                    char2_line_base <= LB_PRESS_START;
                end
                SCR_PLAY: begin
                    char1_en        <= 1'b0;
                    char2_en        <= 1'b0;
                    char1_line_base <= LB_TITLE;
                    char2_line_base <= LB_PRESS_START;
                end
                SCR_RESULT: begin
                    char1_en        <= 1'b1;
                    char2_en        <= 1'b1;
                    char1_line_base <= result_win ? LB_WIN : LB_LOSE;
                    char2_line_base <= LB_PRESS_START;
                end
            endcase
        end
    end

    // Prompt blink: toggles every BLINK_FRAMES ticks regardless of screen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule
